// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
//
// Main controller for the multi-cycle MIPS datapath. Decodes op/funct from
// the IR and walks the datapath through fetch, decode, execute and
// writeback, one state per clock. Memory states (FETCH, MEMRD, MEMWR) wait
// on mem_ready and give up after MEM_WAIT_MAX consecutive stall cycles.
//
// Optional feature (compile-time macro MC_ORI_EN):
//   defined     - op 001101 (ori) executes through ORIEX/ORIWB using the
//                 zero-extend ALU control (001).
//   not defined - op 001101 is treated as an illegal opcode.
//
// Parameters:
//   MEM_WAIT_MAX  stall cycles allowed in a memory state before mem_timeout
//                 pulses and the FSM returns to FETCH (0 = never time out)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (forces all controls to 0)
//   op, funct    instruction[31:26] / instruction[5:0] from the IR
//   zero         ALU zero flag (beq)
//   mem_ready    memory completes the access this cycle
//   pcen         PC register enable
//   irwrite      IR enable
//   regwrite     register file write enable
//   memwrite     memory write strobe
//   iord         memory address select (1 = ALUOut)
//   memtoreg     register write-data select (1 = MDR)
//   regdst       register write-address select (1 = rd)
//   alusrca      ALU A select (0 = PC, 1 = register A)
//   alusrcb      ALU B select (00 B, 01 +4, 10 imm, 11 imm<<2)
//   pcsrc        next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//   alucontrol   010 add, 110 sub, 000 and, 001 or/zero-extend, 111 slt
//   state        current state code (debug)
//   illegal_op   one-cycle pulse on an unsupported opcode/funct
//   mem_timeout  one-cycle pulse when the stall limit is reached
// ----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MC_ORI_EN
        ,
        ORIEX   = 4'd12,
        ORIWB   = 4'd13
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ORI_EN
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Counter wide enough to hold MEM_WAIT_MAX; LAST is the count value
    // during the final permitted stall cycle.
    localparam int unsigned CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

    state_t          state_q;
    state_t          state_n;
    logic [CW-1:0]   stall_cnt;
    logic            mem_state;
    logic            stalled;
    logic            timeout_hit;
    logic [3:0]      rtype_dec;

    // {legal, alucontrol} for an R-type funct field.
    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: rtype_alu = {1'b1, ALU_ADD};
            6'b100010: rtype_alu = {1'b1, ALU_SUB};
            6'b100100: rtype_alu = {1'b1, ALU_AND};
            6'b100101: rtype_alu = {1'b1, ALU_OR};
            6'b101010: rtype_alu = {1'b1, ALU_SLT};
            default:   rtype_alu = 4'b0000;
        endcase
    endfunction

    assign rtype_dec   = rtype_alu(funct);
    assign mem_state   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign stalled     = mem_state && !mem_ready;
    assign timeout_hit = (MEM_WAIT_MAX != 0) && stalled && (stall_cnt == LAST);
    assign state       = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            stall_cnt <= '0;
        end else begin
            state_q <= state_n;
            // FETCH times out back into FETCH, so the state does not change
            // on that cycle; the timeout itself must clear the count.
            if ((state_n != state_q) || timeout_hit) begin
                stall_cnt <= '0;
            end else if (stalled) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state_q;
        pcen        = 1'b0;
        irwrite     = 1'b0;
        regwrite    = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        alucontrol  = ALU_AND;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        case (state_q)
            FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = mem_ready;
                pcen       = mem_ready;
                if (mem_ready) state_n = DECODE;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE:     state_n = RTYPEEX;
                    OP_BEQ:       state_n = BEQEX;
                    OP_ADDI:      state_n = ADDIEX;
                    OP_J:         state_n = JEX;
`ifdef MC_ORI_EN
                    OP_ORI:       state_n = ORIEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_n    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_n    = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_n = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_n  = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) state_n = FETCH;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = rtype_dec[2:0];
                if (rtype_dec[3]) begin
                    state_n = RTYPEWB;
                end else begin
                    illegal_op = 1'b1;
                    state_n    = FETCH;
                end
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_n  = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
                state_n    = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_n    = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_n  = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_n = FETCH;
            end
`ifdef MC_ORI_EN
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_OR;
                state_n    = ORIWB;
            end
            ORIWB: begin
                regwrite = 1'b1;
                state_n  = FETCH;
            end
`endif
            default: state_n = FETCH;
        endcase

        // Stall limit: abandon the access, keep selects but drop enables.
        if (timeout_hit) begin
            mem_timeout = 1'b1;
            state_n     = FETCH;
            pcen        = 1'b0;
            irwrite     = 1'b0;
            memwrite    = 1'b0;
            regwrite    = 1'b0;
        end

        if (reset) begin
            pcen        = 1'b0;
            irwrite     = 1'b0;
            regwrite    = 1'b0;
            memwrite    = 1'b0;
            iord        = 1'b0;
            memtoreg    = 1'b0;
            regdst      = 1'b0;
            alusrca     = 1'b0;
            alusrcb     = 2'b00;
            pcsrc       = 2'b00;
            alucontrol  = 3'b000;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Self-checking bench for mc_control_fsm. Each instruction is expanded into
// a per-cycle list of expected (state, control word) pairs from the
// instruction's recipe, then played against the DUT cycle by cycle.
// Respects the MC_ORI_EN macro in the same way as the design.
// ----------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;

    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    typedef struct {
        int    st;
        int    rdy;   // 0, 1, or 2 = don't care (driven randomly)
        logic  z;
        ctrl_t c;
    } rec_t;

    rec_t  plan[$];
    ctrl_t got;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    assign got = {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                  alusrcb, pcsrc, alucontrol, illegal_op, mem_timeout};

    mc_control_fsm #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- expectation builders ----------------
    function automatic void push(int st, int rdy, logic z, ctrl_t c);
        rec_t r;
        r.st = st; r.rdy = rdy; r.z = z; r.c = c;
        plan.push_back(r);
    endfunction

    // Memory phase: 'stalls' not-ready cycles then one ready cycle. Returns 1
    // when the stall limit aborts the access (timeout cycle replaces it).
    function automatic bit plan_mem(int st, ctrl_t c_wait, ctrl_t c_done, logic z, int stalls);
        ctrl_t t;
        for (int i = 0; i < stalls; i++) begin
            if (i == WAIT_MAX - 1) begin
                t = c_wait;
                t.pcen = 0; t.irwrite = 0; t.memwrite = 0; t.regwrite = 0;
                t.mem_timeout = 1;
                push(st, 0, z, t);
                return 1;
            end
            push(st, 0, z, c_wait);
        end
        push(st, 1, z, c_done);
        return 0;
    endfunction

    function automatic void plan_instr(logic [5:0] o, logic [5:0] f, logic z, int fst, int mst);
        ctrl_t c, d;
        bit    ab;
        c = '0; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
        d = c;  d.pcen = 1; d.irwrite = 1;
        if (plan_mem(0, c, d, z, fst)) return;
        d = '0; d.alusrcb = 2'b11; d.alucontrol = 3'b010;
        case (o)
            6'b100011, 6'b101011: begin
                push(1, 2, z, d);
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
                push(2, 2, z, c);
                c = '0; c.iord = 1;
                if (o == 6'b100011) begin
                    ab = plan_mem(3, c, c, z, mst);
                    if (!ab) begin
                        c = '0; c.memtoreg = 1; c.regwrite = 1;
                        push(4, 2, z, c);
                    end
                end else begin
                    c.memwrite = 1;
                    ab = plan_mem(5, c, c, z, mst);
                end
            end
            6'b000000: begin
                push(1, 2, z, d);
                c = '0; c.alusrca = 1;
                case (f)
                    6'b100000: c.alucontrol = 3'b010;
                    6'b100010: c.alucontrol = 3'b110;
                    6'b100100: c.alucontrol = 3'b000;
                    6'b100101: c.alucontrol = 3'b001;
                    6'b101010: c.alucontrol = 3'b111;
                    default:   c.illegal_op = 1;
                endcase
                push(6, 2, z, c);
                if (!c.illegal_op) begin
                    c = '0; c.regdst = 1; c.regwrite = 1;
                    push(7, 2, z, c);
                end
            end
            6'b000100: begin
                push(1, 2, z, d);
                c = '0; c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z;
                push(8, 2, z, c);
            end
            6'b001000: begin
                push(1, 2, z, d);
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
                push(9, 2, z, c);
                c = '0; c.regwrite = 1;
                push(10, 2, z, c);
            end
            6'b000010: begin
                push(1, 2, z, d);
                c = '0; c.pcsrc = 2'b10; c.pcen = 1;
                push(11, 2, z, c);
            end
`ifdef MC_ORI_EN
            6'b001101: begin
                push(1, 2, z, d);
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b001;
                push(12, 2, z, c);
                c = '0; c.regwrite = 1;
                push(13, 2, z, c);
            end
`endif
            default: begin
                d.illegal_op = 1;
                push(1, 2, z, d);
            end
        endcase
    endfunction

    // Plays the plan; entered and left on a falling edge.
    task automatic run_plan(input string name);
        rec_t r;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            mem_ready = (r.rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(r.rdy);
            zero = r.z;
            #1;
            checks++;
            if (state !== 4'(r.st)) begin
                errors++;
                $display("FAIL %s cyc%0d state: got %0d expected %0d", name, cyc, state, r.st);
            end
            checks++;
            if (got !== r.c) begin
                errors++;
                $display("FAIL %s cyc%0d ctrl (state %0d): got %h expected %h", name, cyc, r.st, got, r.c);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int fst, input int mst);
        op = o; funct = f;
        plan_instr(o, f, z, fst, mst);
        run_plan(name);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1; mem_ready = 0; zero = 0; op = 6'b100011; funct = 6'b100000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = 1'(i);
            #1;
            checks++;
            if (state !== 4'd0) begin
                errors++;
                $display("FAIL reset_state: got %0d expected 0", state);
            end
            checks++;
            if (got !== ctrl_t'(0)) begin
                errors++;
                $display("FAIL reset_ctrl: got %h expected 0", got);
            end
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_rtype_sub();
        do_instr("rtype_sub", 6'b000000, 6'b100010, 0, 0, 0);
    endtask

    task automatic test_lw_stall();
        do_instr("lw_stall", 6'b100011, 6'h00, 0, 0, 3);
    endtask

    task automatic test_sw_stall();
        do_instr("sw_stall", 6'b101011, 6'h00, 0, 1, 2);
        do_instr("sw_nostall", 6'b101011, 6'h00, 0, 0, 0);
    endtask

    task automatic test_beq();
        do_instr("beq_taken", 6'b000100, 6'h00, 1, 0, 0);
        do_instr("beq_not", 6'b000100, 6'h00, 0, 0, 0);
    endtask

    task automatic test_illegal();
        do_instr("illegal_op", 6'b111111, 6'h00, 0, 0, 0);
        do_instr("ori", 6'b001101, 6'h00, 0, 0, 0);
        do_instr("bad_funct", 6'b000000, 6'b111111, 0, 0, 0);
    endtask

    task automatic test_timeout();
        do_instr("fetch_timeout", 6'b001000, 6'h00, 0, WAIT_MAX, 0);
        do_instr("after_timeout", 6'b001000, 6'h00, 0, 0, 0);
        do_instr("fetch_14", 6'b000010, 6'h00, 0, WAIT_MAX - 1, 0);
        do_instr("sw_timeout", 6'b101011, 6'h00, 0, 0, WAIT_MAX);
        do_instr("lw_14", 6'b100011, 6'h00, 0, 0, WAIT_MAX - 1);
        do_instr("lw_timeout", 6'b100011, 6'h00, 0, 0, WAIT_MAX);
    endtask

    task automatic test_reset_mid();
        ctrl_t c;
        op = 6'b000000; funct = 6'b100000;
        plan_instr(op, funct, 0, 0, 0);
        void'(plan.pop_back());   // stop before RTYPEWB plays
        run_plan("reset_mid_pre");
        reset = 1; mem_ready = 1;
        #1;
        checks++;
        if (state !== 4'd7) begin
            errors++;
            $display("FAIL reset_mid_state: got %0d expected 7", state);
        end
        checks++;
        if (got !== ctrl_t'(0)) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got %h expected 0", got);
        end
        @(negedge clk);
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_next: got %0d expected 0", state);
        end
        reset = 0;
        c = '0;
        do_instr("after_reset_mid", 6'b000010, 6'h00, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops[8];
        logic [5:0] fn[5];
        logic [5:0] o, f;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b001101, 6'b111111};
        fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 80; n++) begin
            o = ops[$urandom_range(0, 7)];
            if (o == 6'b111111) begin
                o = 6'($urandom_range(0, 63));
                if (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                    o = 6'b111111;
            end
            f = ($urandom_range(0, 3) != 0) ? fn[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            do_instr("random", o, f, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 4), $urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
